// File: rtl/karlsen_ladder_mc_pkg.sv
// Shared types, widths and the saturation helper for the multi-channel Karlsen ladder.
package karlsen_pkg;
    localparam int WMULT = 18;
    localparam int SHIFT = 16;

    typedef enum logic [1:0] {LP4, LP2, BP, HP} filter_mode_t;

    typedef enum logic [3:0] {
        IDLE, LOAD, RES, CLIP, SAT, S1, S2, S3, S4, DONE
    } state_t;

    // Clamp to the signed range of a w-bit word, returned sign-extended to WMULT bits.
    function automatic logic signed [WMULT-1:0] sat(input logic signed [31:0] x, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (x > hi) return WMULT'(hi);
        if (x < lo) return WMULT'(lo);
        return WMULT'(x);
    endfunction
endpackage

// File: rtl/karlsen_ladder_mc_if.sv
// Sample/control bundle between the channel sources, the ladder and the output mixer.
interface karlsen_ladder_mc_if #(
    parameter int W    = 16,
    parameter int N_CH = 4
);
    logic                strobe;
    logic [2*N_CH-1:0]   mode;
    logic [W*N_CH-1:0]   g;
    logic [W*N_CH-1:0]   resonance;
    logic [W*N_CH-1:0]   sample_in;
    logic [W*N_CH-1:0]   sample_out;
    logic                out_valid;
    logic                busy;
    logic                overrun;

    modport master (
        output strobe, mode, g, resonance, sample_in,
        input  sample_out, out_valid, busy, overrun
    );

    modport slave (
        input  strobe, mode, g, resonance, sample_in,
        output sample_out, out_valid, busy, overrun
    );
endinterface

// File: rtl/karlsen_ladder_mc_smul.sv
// Combinational one-pole blend a + ((b - a) * s >>> 16); the only multiplier in the ladder.
module ladder_smul_18x18
    import karlsen_pkg::*;
(
    input  logic signed [WMULT-1:0] a,
    input  logic signed [WMULT-1:0] b,
    input  logic signed [WMULT-1:0] s,
    output logic signed [WMULT-1:0] y
);
    logic signed [WMULT-1:0]   diff;
    logic signed [2*WMULT-1:0] prod;

    assign diff = b - a;
    assign prod = (2*WMULT)'(diff) * (2*WMULT)'(s);
    assign y    = a + WMULT'(prod >>> SHIFT);
endmodule

// File: rtl/karlsen_ladder_mc.sv
// Time-shared Karlsen ladder: every strobe walks all channels through one multiplier, then publishes.
module karlsen_ladder_mc
    import karlsen_pkg::*;
#(
    parameter int W    = 16,
    parameter int N_CH = 4
)(
    input logic              clk,
    input logic              rst_n,
    karlsen_ladder_mc_if.slave bus
);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int RW = WMULT + 2;
    localparam logic [CW-1:0] LAST = CW'(N_CH - 1);

    state_t                  state, state_nx;
    logic [CW-1:0]           ch;
    logic                    overrun_q;
    logic [W*N_CH-1:0]       out_q;

    logic signed [WMULT-1:0] a1 [N_CH];
    logic signed [WMULT-1:0] a2 [N_CH];
    logic signed [WMULT-1:0] a3 [N_CH];
    logic signed [WMULT-1:0] a4 [N_CH];
    logic signed [WMULT-1:0] in_q  [N_CH];
    logic signed [WMULT-1:0] g_q   [N_CH];
    logic signed [WMULT-1:0] res_q [N_CH];
    filter_mode_t            mode_q [N_CH];
    logic signed [W-1:0]     hold   [N_CH];

    logic signed [WMULT-1:0] x_p0, g_p0, r_p0, res_p1, clip_p3;
    logic signed [RW-1:0]    raw_p2;
    filter_mode_t            m_p0;
    logic signed [WMULT-1:0] ma, mb, ms, my;
    logic signed [W-1:0]     tap;

    function automatic logic signed [WMULT-1:0] clamp0(input logic signed [W-1:0] v);
        return v[W-1] ? '0 : WMULT'(v);
    endfunction

    ladder_smul_18x18 u_smul (.a(ma), .b(mb), .s(ms), .y(my));

    always_comb begin
        ma = x_p0;
        mb = a4[ch];
        ms = r_p0;
        case (state)
            S1:      begin ma = a1[ch]; mb = clip_p3; ms = g_p0; end
            S2:      begin ma = a2[ch]; mb = a1[ch];  ms = g_p0; end
            S3:      begin ma = a3[ch]; mb = a2[ch];  ms = g_p0; end
            S4:      begin ma = a4[ch]; mb = a3[ch];  ms = g_p0; end
            default: ;
        endcase
    end

    // In S4 the a1/a2 entries already hold this pass's values; my is the new a4.
    always_comb begin
        tap = W'(my);
        case (m_p0)
            LP4: tap = W'(my);
            LP2: tap = W'(a2[ch]);
            BP:  tap = W'(sat(32'(a1[ch]) - 32'(a2[ch]), W));
            HP:  tap = W'(sat(32'(clip_p3) - 32'(a1[ch]), W));
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.strobe) state_nx = LOAD;
            LOAD:    state_nx = RES;
            RES:     state_nx = CLIP;
            CLIP:    state_nx = SAT;
            SAT:     state_nx = S1;
            S1:      state_nx = S2;
            S2:      state_nx = S3;
            S3:      state_nx = S4;
            S4:      state_nx = (ch == LAST) ? DONE : LOAD;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ch        <= '0;
            overrun_q <= 1'b0;
            out_q     <= '0;
            for (int c = 0; c < N_CH; c++) begin
                a1[c] <= '0;
                a2[c] <= '0;
                a3[c] <= '0;
                a4[c] <= '0;
            end
        end else begin
            state <= state_nx;
            if (bus.strobe && state != IDLE) overrun_q <= 1'b1;
            case (state)
                IDLE: ch <= '0;
                S1:   a1[ch] <= my;
                S2:   a2[ch] <= my;
                S3:   a3[ch] <= my;
                S4: begin
                    a4[ch] <= my;
                    ch     <= ch + CW'(1);
                    // Publish all channels together; the last one comes straight from the tap.
                    if (ch == LAST)
                        for (int c = 0; c < N_CH; c++)
                            out_q[c*W +: W] <= (CW'(c) == ch) ? tap : hold[c];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (bus.strobe && state == IDLE) begin
            for (int c = 0; c < N_CH; c++) begin
                in_q[c]   <= WMULT'($signed(bus.sample_in[c*W +: W]));
                g_q[c]    <= clamp0(bus.g[c*W +: W]);
                res_q[c]  <= clamp0(bus.resonance[c*W +: W]) <<< 2;
                mode_q[c] <= filter_mode_t'(bus.mode[2*c +: 2]);
            end
        end
        case (state)
            LOAD: begin
                x_p0 <= in_q[ch];
                g_p0 <= g_q[ch];
                r_p0 <= res_q[ch];
                m_p0 <= mode_q[ch];
            end
            RES:  res_p1  <= my;
            CLIP: raw_p2  <= (RW'(x_p0) <<< 1) - RW'(res_p1);
            SAT:  clip_p3 <= sat(32'(raw_p2), W);
            S4:   hold[ch] <= tap;
            default: ;
        endcase
    end

    assign bus.sample_out = out_q;
    assign bus.out_valid  = (state == DONE);
    assign bus.busy       = (state != IDLE) && (state != DONE);
    assign bus.overrun    = overrun_q;
endmodule
